// File: rtl/fetch_queue_if.sv
// fetch_queue_if: handshake bundle between instruction fetch, the fetch queue and decode.
//   in_valid/in_pc/in_instr/in_ready : fetch -> queue push side
//   out_valid/out_pc/out_instr/out_ready : queue -> decode pop side
//   flush : redirect, discards all queued entries
//   count : current occupancy 0..DEPTH
// Modports: slave = the queue, master = the fetch/decode environment driving it.
interface fetch_queue_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic            in_valid;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_instr;
  logic            in_ready;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            out_ready;
  logic            flush;
  logic [CW-1:0]   count;

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, out_pc, out_instr, count
  );

  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: in-order buffer of DEPTH {pc, instr} pairs between fetch and decode.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : fetch_queue_if.slave (push side, pop side, flush, count)
// All outputs are decoded from registered state only; there is no bypass from in_* to out_*.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  entry_t [DEPTH-1:0] mem;
  logic   [AW-1:0]    rd_ptr, wr_ptr;
  logic   [CW-1:0]    cnt;
  logic               full, empty, push, pop;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // Flush wins over both handshakes so nothing in the redirect cycle survives.
  assign push = bus.in_valid & ~full & ~bus.flush;
  assign pop  = ~empty & bus.out_ready & ~bus.flush;

  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  assign bus.out_pc    = empty ? '0 : mem[rd_ptr].pc;
  assign bus.out_instr = empty ? '0 : mem[rd_ptr].instr;
  assign bus.count     = cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: stale slots are never visible because outputs are gated by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: bus.in_pc, instr: bus.in_instr};
  end
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  fetch_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] instr_of(input logic [XLEN-1:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {pc, instr} pairs following the push/pop/flush rules.
  typedef struct {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } ent_t;
  ent_t mq[$];

  always @(posedge clk or posedge reset) begin
    bit p, q;
    if (reset || bus.flush) begin
      mq.delete();
    end else begin
      p = bus.in_valid && (mq.size() < DEPTH);
      q = (mq.size() > 0) && bus.out_ready;
      if (q) void'(mq.pop_front());
      if (p) mq.push_back('{pc: bus.in_pc, instr: bus.in_instr});
    end
  end

  // Every falling edge: DUT outputs must match the model.
  always @(negedge clk) begin
    logic [XLEN-1:0] epc, ein;
    epc = (mq.size() > 0) ? mq[0].pc : '0;
    ein = (mq.size() > 0) ? mq[0].instr : '0;
    chk("cmp_count",     bus.count,     64'(mq.size()));
    chk("cmp_out_valid", bus.out_valid, 64'(mq.size() != 0));
    chk("cmp_in_ready",  bus.in_ready,  64'(mq.size() != DEPTH));
    chk("cmp_out_pc",    bus.out_pc,    64'(epc));
    chk("cmp_out_instr", bus.out_instr, 64'(ein));
  end

  // Drive one cycle of inputs, let the edge happen, return 1 time unit after it.
  task automatic cyc(input logic v, input logic [XLEN-1:0] pc, input logic rdy, input logic fl);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_instr  = instr_of(pc);
    bus.out_ready = rdy;
    bus.flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit vt[10];
    bit rt[10];
    vt = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1};
    rt = '{0, 0, 1, 1, 0, 1, 0, 1, 1, 1};

    reset = 1'b1;
    bus.in_valid = 0; bus.in_pc = '0; bus.in_instr = '0; bus.out_ready = 0; bus.flush = 0;
    #12 reset = 1'b0;
    #1;
    chk("rst_count", bus.count, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_pc", bus.out_pc, 0);

    // 1: async reset mid-stream with count=3
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) cyc(1, 32'h40 + 4 * i, 0, 0);
    chk("t1_pre_count", bus.count, 3);
    #2 reset = 1'b1;
    #1;
    chk("t1_count", bus.count, 0);
    chk("t1_out_valid", bus.out_valid, 0);
    chk("t1_out_pc", bus.out_pc, 0);
    chk("t1_in_ready", bus.in_ready, 1);
    #2 reset = 1'b0;

    // 2: fill to full, 5th push refused
    for (int i = 0; i < 4; i++) cyc(1, 4 * i, 0, 0);
    chk("t2_count", bus.count, 4);
    chk("t2_in_ready", bus.in_ready, 0);
    chk("t2_head", bus.out_pc, 0);
    cyc(1, 32'h10, 0, 0);
    chk("t2_count_refused", bus.count, 4);
    chk("t2_head_refused", bus.out_pc, 0);

    // 3: drain; first drain cycle also offers a push that a full queue must refuse
    for (int i = 0; i < 4; i++) begin
      chk("t3_head", bus.out_pc, 4 * i);
      chk("t3_head_instr", bus.out_instr, instr_of(4 * i));
      cyc(i == 0, 32'h14, 1, 0);
      if (i == 0) chk("t3_full_pop_count", bus.count, 3);
    end
    chk("t3_out_valid", bus.out_valid, 0);
    chk("t3_count", bus.count, 0);
    chk("t3_out_pc_gated", bus.out_pc, 0);

    // 4: steady stream, 1-cycle latency, count stays 1
    for (int i = 0; i < 16; i++) begin
      cyc(1, 32'h100 + 4 * i, 1, 0);
      chk("t4_count", bus.count, 1);
      chk("t4_head", bus.out_pc, 32'h100 + 4 * i);
    end
    cyc(0, 0, 1, 0);
    chk("t4_drained", bus.count, 0);

    // 5: flush with push and pop offered in the same cycle
    cyc(1, 32'h200, 0, 0);
    cyc(1, 32'h204, 0, 0);
    chk("t5_pre_count", bus.count, 2);
    cyc(1, 32'h208, 1, 1);
    chk("t5_count", bus.count, 0);
    chk("t5_out_valid", bus.out_valid, 0);
    chk("t5_in_ready", bus.in_ready, 1);
    cyc(1, 32'h300, 0, 0);
    chk("t5_next_head", bus.out_pc, 32'h300);
    chk("t5_next_count", bus.count, 1);
    cyc(0, 0, 1, 0);

    // 6: mixed stalls so both pointers wrap; order checked by the model every cycle
    for (int i = 0; i < 10; i++) begin
      cyc(vt[i], 32'h400 + 4 * i, rt[i], 0);
      chk("t6_count_range", 64'(bus.count <= DEPTH), 1);
    end
    chk("t6_count_end", bus.count, 2);
    chk("t6_head_end", bus.out_pc, 32'h420);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    chk("t6_drained", bus.count, 0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
